// File: rtl/product_accumulator.sv
// product_accumulator: sums BEATS unsigned 8-bit products into an ACC_W-bit result with a sticky overflow flag.
// Define ACC_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module product_accumulator #(
    parameter int ACC_W = 12,
    parameter int BEATS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);
    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum;
    logic             accept;

    assign in_ready  = state_q != OUT;
    assign out_valid = state_q == OUT;
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;
    assign accept    = in_valid && in_ready;
    // One extra bit exposes the carry that marks an overflowing addition
    assign sum       = {1'b0, acc_q} + (ACC_W+1)'(in_product);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (state_q == IDLE && accept) begin
            acc_d   = ACC_W'(in_product);
            ovf_d   = 1'b0;
            cnt_d   = 8'd1;
            state_d = (BEATS == 1) ? OUT : ACC;
        end else if (state_q == ACC && accept) begin
`ifdef ACC_SAT_EN
            acc_d   = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
            acc_d   = sum[ACC_W-1:0];
`endif
            ovf_d   = ovf_q | sum[ACC_W];
            cnt_d   = cnt_q + 8'd1;
            state_d = (cnt_d == 8'(BEATS)) ? OUT : ACC;
        end else if (state_q == OUT && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule
